// File: rtl/wb_rr_arbiter.sv
// Four-master round-robin Wishbone arbiter for one shared slave port, with a
// bus watchdog that turns a never-acknowledged slave cycle into an error.
module wb_rr_arbiter #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    m_cyc_i,
  input  logic [3:0]    m_stb_i,
  input  logic [3:0]    m_we_i,
  input  logic [127:0]  m_adr_i,
  input  logic [127:0]  m_dat_i,
  input  logic [15:0]   m_sel_i,
  output logic [31:0]   m_dat_o,
  output logic [3:0]    m_ack_o,
  output logic [3:0]    m_err_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [31:0]   s_adr_o,
  output logic [31:0]   s_dat_o,
  output logic [3:0]    s_sel_o,
  input  logic [31:0]   s_dat_i,
  input  logic          s_ack_i,
  output logic [1:0]    gnt_o,
  output logic          busy_o,
  output logic          tmo_o
);

  // Handshake: a master owns the slave from the grant until it drops its CYC;
  // STB/ACK then follow classic Wishbone, and ERR replaces ACK on a timeout.

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam bit             WDOG_EN  = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_gnt;
  logic [1:0]       r_last;
  logic [CNT_W-1:0] r_wdog;
  logic [CNT_W-1:0] w_wdog_nxt;

  logic             w_busy;
  logic             w_any;
  logic [1:0]       w_pick;
  logic             w_g_cyc;
  logic             w_g_stb;
  logic             w_stall;
  logic             w_fire;

  assign w_busy  = (r_state == ST_BUSY);
  assign w_any   = |m_cyc_i;
  assign w_g_cyc = m_cyc_i[r_gnt];
  assign w_g_stb = m_stb_i[r_gnt];
  assign w_stall = w_busy & w_g_stb & ~s_ack_i;
  // Ack arriving in the expiry cycle suppresses the error.
  assign w_fire  = WDOG_EN & w_stall & (r_wdog == TMO_LAST);

  // Round-robin scan starting just after the last granted master.
  always_comb begin
    logic       v_found;
    logic [1:0] v_idx;
    w_pick  = 2'd0;
    v_found = 1'b0;
    v_idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      v_idx = r_last + 2'(k);
      if (!v_found && m_cyc_i[v_idx]) begin
        w_pick  = v_idx;
        v_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_any) w_state_nxt = ST_BUSY;
      ST_BUSY: if (!w_g_cyc) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Counter saturates so a disabled watchdog never wraps back to zero.
  always_comb begin
    w_wdog_nxt = '0;
    if (w_stall && !w_fire) begin
      if (r_wdog != '1) w_wdog_nxt = r_wdog + CNT_W'(1);
      else              w_wdog_nxt = r_wdog;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_gnt   <= 2'd0;
      r_last  <= 2'd3;
      r_wdog  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wdog  <= w_wdog_nxt;
      if (r_state == ST_IDLE && w_any) begin
        r_gnt  <= w_pick;
        r_last <= w_pick;
      end
    end
  end

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = 32'd0;
    s_dat_o = 32'd0;
    s_sel_o = 4'd0;
    m_ack_o = 4'd0;
    m_err_o = 4'd0;
    tmo_o   = 1'b0;
    if (w_busy) begin
      s_cyc_o        = w_g_cyc;
      s_stb_o        = w_g_stb & ~w_fire;
      s_we_o         = m_we_i[r_gnt];
      s_adr_o        = m_adr_i[{r_gnt, 5'd0} +: 32];
      s_dat_o        = m_dat_i[{r_gnt, 5'd0} +: 32];
      s_sel_o        = m_sel_i[{r_gnt, 2'd0} +: 4];
      m_ack_o[r_gnt] = s_ack_i;
      m_err_o[r_gnt] = w_fire;
      tmo_o          = w_fire;
    end
  end

  assign m_dat_o = s_dat_i;
  assign gnt_o   = r_gnt;
  assign busy_o  = w_busy;

endmodule
